// File: rtl/axilite_tg_pkg.sv
// Shared definitions for the AXI4-Lite traffic generator.
//   tg_state_e      : controller state encoding
//   AXI_RESP_*      : AXI response codes used when judging B/R responses
//   ERR_CNT_WIDTH   : width of the saturating error counter
//   sat_inc()       : increment that sticks at all-ones
package axilite_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_FIN     = 3'd5
  } tg_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int ERR_CNT_WIDTH = 16;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (v == {ERR_CNT_WIDTH{1'b1}}) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/axilite_tg_watchdog.sv
// Per-phase watchdog for the traffic generator.
//   clk, rst : clock, synchronous active-high reset
//   clear    : reload the timer (asserted on every controller state change)
//   enable   : count while a transaction phase is in progress
//   expired  : TIMEOUT cycles have elapsed in the current phase
// Implemented as a down-counter loaded with TIMEOUT-1; the terminal count
// is flagged combinationally so the controller reacts on the same edge and
// timeout becomes visible exactly TIMEOUT cycles after phase entry.
module axilite_tg_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/axilite_traffic_gen.sv
// Scripted AXI4-Lite master: writes NUM_TXN words at BASE_ADDR + i*ADDR_STRIDE
// carrying DATA_SEED + i*DATA_INCR, then reads each back and checks it.
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle launch pulse (ignored unless idle)
//   busy/done/pass    : run status; done and pass hold until the next start
//   timeout           : run aborted by the per-phase watchdog
//   err_count         : saturating count of bad responses / data mismatches
//   m_axi_aw*/w*/b*   : write channels (one outstanding write)
//   m_axi_ar*/r*      : read channels (one outstanding read)
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for start
// WR_REQ     | awvalid/wvalid held until each has its own handshake
// WR_RESP    | bready high, waiting for the write response
// RD_REQ     | arvalid held until arready
// RD_RESP    | rready high, waiting for read data to compare
// FIN        | publish done/pass, return to IDLE
module axilite_traffic_gen
  import axilite_tg_pkg::*;
#(
  parameter int                     ADDR_WIDTH   = 64,
  parameter int                     DATA_WIDTH   = 64,
  parameter int                     STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int                     NUM_TXN      = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
  parameter int                     ADDR_STRIDE  = 8,
  parameter logic [DATA_WIDTH-1:0]  DATA_SEED    = DATA_WIDTH'(64'hA5A5_0000_5A5A_0000),
  parameter logic [DATA_WIDTH-1:0]  DATA_INCR    = DATA_WIDTH'(64'h0000_0001_0000_0001),
  parameter int                     TIMEOUT      = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     m_axi_awvalid,
  output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
  input  logic                     m_axi_awready,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  output logic [STROBE_WIDTH-1:0]  m_axi_wstrb,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  input  logic [1:0]               m_axi_bresp,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  input  logic [1:0]               m_axi_rresp,
  input  logic [DATA_WIDTH-1:0]    m_axi_rdata
);

  localparam int IDX_W = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);

  tg_state_e             state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  last;
  logic                  aw_ok, w_ok;
  logic                  rd_bad;
  logic                  wd_clear, wd_enable, wd_expired;

  // Address and data are pure functions of the index, so they are stable for
  // as long as a request is held.
  assign cur_addr = BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STRIDE);
  assign cur_data = DATA_SEED + DATA_WIDTH'(idx) * DATA_INCR;

  assign m_axi_awaddr = cur_addr;
  assign m_axi_araddr = cur_addr;
  assign m_axi_wdata  = cur_data;
  assign m_axi_wstrb  = '1;

  assign last = (idx == LAST_IDX);

  // A channel is satisfied once its valid has already dropped or it is being
  // accepted this cycle; AW and W may complete in either order.
  assign aw_ok  = !m_axi_awvalid || m_axi_awready;
  assign w_ok   = !m_axi_wvalid  || m_axi_wready;
  // A bad code together with bad data is still a single error.
  assign rd_bad = (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rdata != cur_data);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_WR_REQ;
      ST_WR_REQ:  if (wd_expired)      state_nxt = ST_FIN;
                  else if (aw_ok && w_ok) state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (wd_expired)      state_nxt = ST_FIN;
                  else if (m_axi_bvalid) state_nxt = last ? ST_RD_REQ : ST_WR_REQ;
      ST_RD_REQ:  if (wd_expired)      state_nxt = ST_FIN;
                  else if (m_axi_arready) state_nxt = ST_RD_RESP;
      ST_RD_RESP: if (wd_expired)      state_nxt = ST_FIN;
                  else if (m_axi_rvalid) state_nxt = last ? ST_FIN : ST_RD_REQ;
      ST_FIN:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign wd_clear  = (state_nxt != state);
  assign wd_enable = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                     (state == ST_RD_REQ) || (state == ST_RD_RESP);

  axilite_tg_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx           <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (wd_expired) begin
            timeout       <= 1'b1;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
          end else begin
            if (m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
            if (aw_ok && w_ok) m_axi_bready  <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (wd_expired) begin
            timeout      <= 1'b1;
            m_axi_bready <= 1'b0;
          end else if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != AXI_RESP_OKAY) err_count <= sat_inc(err_count);
            if (last) begin
              idx           <= '0;
              m_axi_arvalid <= 1'b1;
            end else begin
              idx           <= idx + IDX_W'(1);
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end
          end
        end
        ST_RD_REQ: begin
          if (wd_expired) begin
            timeout       <= 1'b1;
            m_axi_arvalid <= 1'b0;
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        ST_RD_RESP: begin
          if (wd_expired) begin
            timeout      <= 1'b1;
            m_axi_rready <= 1'b0;
          end else if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (rd_bad) err_count <= sat_inc(err_count);
            if (!last) begin
              idx           <= idx + IDX_W'(1);
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_count == '0) && !timeout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_traffic_gen.sv
// Bench for axilite_traffic_gen: a randomized AXI4-Lite responder with a
// small memory, fault injection and a scoreboard fed from the address/data
// formulas; a negedge monitor checks every handshake against the queues.
module tb_axilite_traffic_gen;
  import axilite_tg_pkg::*;

  localparam int N      = 8;
  localparam int TO     = 32;
  localparam int STRIDE = 8;
  localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;
  localparam logic [63:0] SEED = 64'hA5A5_0000_5A5A_0000;
  localparam logic [63:0] INCR = 64'h0000_0001_0000_0001;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axilite_traffic_gen #(
    .ADDR_WIDTH (64), .DATA_WIDTH (64), .STROBE_WIDTH (8), .NUM_TXN (N),
    .BASE_ADDR (BASE), .ADDR_STRIDE (STRIDE), .DATA_SEED (SEED),
    .DATA_INCR (INCR), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .busy (busy), .done (done),
    .pass (pass), .timeout (timeout), .err_count (err_count),
    .m_axi_awvalid (awvalid), .m_axi_awaddr (awaddr), .m_axi_awready (awready),
    .m_axi_wvalid (wvalid), .m_axi_wready (wready), .m_axi_wstrb (wstrb),
    .m_axi_wdata (wdata), .m_axi_bvalid (bvalid), .m_axi_bready (bready),
    .m_axi_bresp (bresp), .m_axi_arvalid (arvalid), .m_axi_arready (arready),
    .m_axi_araddr (araddr), .m_axi_rvalid (rvalid), .m_axi_rready (rready),
    .m_axi_rresp (rresp), .m_axi_rdata (rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s %s", name, what);
  endtask

  function automatic logic [63:0] model_addr(input int i);
    return BASE + 64'(i) * 64'(STRIDE);
  endfunction

  function automatic logic [63:0] model_data(input int i);
    return SEED + 64'(i) * INCR;
  endfunction

  // scoreboard
  logic [63:0] exp_aw[$], exp_w[$], exp_ar[$];
  int exp_err;

  // responder configuration
  int max_delay = 0, aw_fix = -1;
  bit drop_b = 0;
  int bad_b_pct = 0, bad_r_pct = 0, corrupt_pct = 0;
  int bad_b_idx = -1, bad_r_idx = -1, corrupt_idx = -1;
  int wr_n, rd_n;

  // responder state
  logic [63:0] mem [logic [63:0]];
  logic [63:0] q_awaddr[$], q_wdata[$];
  logic [63:0] ar_cap, wa, wd, r_data_pend;
  logic [1:0]  b_code, r_code;
  bit hs_aw, hs_w, hs_b, hs_ar, hs_r, s_aw, s_w, s_ar;
  bit b_pend, r_pend, bad, corrupt;
  int b_dly, r_dly, aw_age, w_age, ar_age, aw_tgt, w_tgt, ar_tgt;

  function automatic int pick_delay();
    return (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
  endfunction

  initial begin : responder
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    b_pend = 0; r_pend = 0; aw_age = 0; w_age = 0; ar_age = 0;
    aw_tgt = 0; w_tgt = 0; ar_tgt = 0;
    forever begin
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      if (hs_aw) q_awaddr.push_back(awaddr);
      if (hs_w)  q_wdata.push_back(wdata);
      if (hs_ar) ar_cap = araddr;
      s_aw = awvalid; s_w = wvalid; s_ar = arvalid;
      @(posedge clk); #2;
      if (rst) begin
        q_awaddr.delete(); q_wdata.delete(); mem.delete();
        b_pend = 0; r_pend = 0; bvalid = 0; rvalid = 0;
        awready = 0; wready = 0; arready = 0;
        aw_age = 0; w_age = 0; ar_age = 0; aw_tgt = 0; w_tgt = 0; ar_tgt = 0;
        continue;
      end
      if (hs_aw) begin aw_age = 0; aw_tgt = pick_delay(); end else if (s_aw) aw_age++;
      if (hs_w)  begin w_age = 0;  w_tgt = pick_delay();  end else if (s_w)  w_age++;
      if (hs_ar) begin ar_age = 0; ar_tgt = pick_delay(); end else if (s_ar) ar_age++;
      if (hs_b) bvalid = 0;
      if (hs_r) rvalid = 0;
      if (q_awaddr.size() > 0 && q_wdata.size() > 0 && !b_pend && !bvalid) begin
        wa = q_awaddr.pop_front();
        wd = q_wdata.pop_front();
        mem[wa] = wd;
        bad = (wr_n == bad_b_idx) || (int'($urandom_range(0, 99)) < bad_b_pct);
        b_code = bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (bad) exp_err++;
        wr_n++;
        b_pend = 1;
        b_dly = pick_delay();
      end
      if (b_pend && !drop_b) begin
        if (b_dly == 0) begin bvalid = 1; bresp = b_code; b_pend = 0; end
        else b_dly--;
      end
      if (hs_ar) begin
        r_data_pend = mem.exists(ar_cap) ? mem[ar_cap] : 64'h0;
        if (rd_n == corrupt_idx) r_data_pend[0] = ~r_data_pend[0];
        else if (int'($urandom_range(0, 99)) < corrupt_pct)
          r_data_pend = r_data_pend ^ (64'h1 << $urandom_range(0, 63));
        bad = (rd_n == bad_r_idx) || (int'($urandom_range(0, 99)) < bad_r_pct);
        r_code = bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (bad || r_data_pend != model_data(rd_n)) exp_err++;
        rd_n++;
        r_pend = 1;
        r_dly = pick_delay();
      end
      if (r_pend) begin
        if (r_dly == 0) begin rvalid = 1; rdata = r_data_pend; rresp = r_code; r_pend = 0; end
        else r_dly--;
      end
      awready = awvalid && (aw_age >= ((aw_fix >= 0) ? aw_fix : aw_tgt));
      wready  = wvalid && (w_age >= w_tgt);
      arready = arvalid && (ar_age >= ar_tgt);
    end
  end

  // monitor: handshakes and hold rules, sampled where all signals are stable
  bit p_aw_wait, p_w_wait, p_ar_wait, p_w_hs;
  logic [63:0] p_awaddr, p_wdata, p_araddr;

  initial begin : monitor
    p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0; p_w_hs = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0; p_w_hs = 0;
        continue;
      end
      if (p_aw_wait) begin
        chk("aw_hold_valid", awvalid, 1'b1);
        chk("aw_hold_addr", awaddr, p_awaddr);
      end
      if (p_w_wait) begin
        chk("w_hold_valid", wvalid, 1'b1);
        chk("w_hold_data", wdata, p_wdata);
      end
      if (p_ar_wait) begin
        chk("ar_hold_valid", arvalid, 1'b1);
        chk("ar_hold_addr", araddr, p_araddr);
      end
      if (p_w_hs) chk("w_drop_after_hs", wvalid, 1'b0);
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) fail_now("aw_extra", "unexpected write address");
        else chk("awaddr", awaddr, exp_aw.pop_front());
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) fail_now("w_extra", "unexpected write data");
        else chk("wdata", wdata, exp_w.pop_front());
        chk("wstrb", wstrb, 8'hFF);
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) fail_now("ar_extra", "unexpected read address");
        else chk("araddr", araddr, exp_ar.pop_front());
      end
      if (bvalid && bready) chk("req_during_b", {awvalid, wvalid, arvalid}, 3'b000);
      p_aw_wait = awvalid && !awready; p_awaddr = awaddr;
      p_w_wait  = wvalid && !wready;   p_wdata  = wdata;
      p_ar_wait = arvalid && !arready; p_araddr = araddr;
      p_w_hs    = wvalid && wready;
    end
  end

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1; start = 0;
    @(posedge clk); #1;
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_err_count"}, err_count, 16'h0);
    chk({tag, "_valids"}, {awvalid, wvalid, arvalid}, 3'b000);
    chk({tag, "_readies"}, {bready, rready}, 2'b00);
    chk({tag, "_addr_idx0"}, awaddr, model_addr(0));
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    rst = 0;
  endtask

  task automatic start_run();
    exp_err = 0; wr_n = 0; rd_n = 0;
    for (int i = 0; i < N; i++) begin
      exp_aw.push_back(model_addr(i));
      exp_w.push_back(model_data(i));
      exp_ar.push_back(model_addr(i));
    end
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int poke, output int cyc);
    bit ok;
    ok = 0; cyc = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      start = (n == poke);
      if (done) begin cyc = n; ok = 1; break; end
    end
    start = 0;
    if (!ok) fail_now("done_wait", "done not seen within 3000 cycles");
  endtask

  task automatic check_result(input string tag, input bit exp_to);
    bit exp_pass;
    exp_pass = (exp_err == 0) && !exp_to;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_timeout"}, timeout, exp_to);
    chk({tag, "_err_count"}, err_count, 16'(exp_err));
    chk({tag, "_pass"}, pass, exp_pass);
    if (!exp_to) begin
      chk({tag, "_writes_left"}, exp_aw.size(), 0);
      chk({tag, "_reads_left"}, exp_ar.size(), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_hold"}, {done, pass}, {1'b1, exp_pass});
  endtask

  int cyc;
  bit seen;

  initial begin : main
    rst = 1; start = 0;
    do_reset("reset");

    // zero-wait clean run with exact latency
    max_delay = 0;
    start_run();
    wait_done(-1, cyc);
    chk("zero_wait_latency", cyc, 4 * N + 1);
    check_result("nominal", 0);

    // AW accepted 5 cycles late, W immediate
    aw_fix = 5;
    start_run();
    wait_done(-1, cyc);
    check_result("skew", 0);
    aw_fix = -1;

    // bad B on write 1, bad R (good data) on read 2
    bad_b_idx = 1; bad_r_idx = 2;
    start_run();
    wait_done(-1, cyc);
    check_result("bad_resp", 0);
    chk("bad_resp_count2", err_count, 16'd2);
    bad_b_idx = -1; bad_r_idx = -1;

    // bit 0 flipped on read 3
    corrupt_idx = 3;
    start_run();
    wait_done(-1, cyc);
    check_result("corrupt", 0);
    chk("corrupt_count1", err_count, 16'd1);
    corrupt_idx = -1;

    // randomized delays and faults, one run with a start pulse while busy
    for (int r = 0; r < 6; r++) begin
      max_delay   = r;
      bad_b_pct   = (r >= 3) ? 25 : 0;
      bad_r_pct   = (r >= 3) ? 25 : 0;
      corrupt_pct = (r >= 2) ? 20 : 0;
      start_run();
      wait_done((r == 4) ? 12 : -1, cyc);
      check_result($sformatf("rand%0d", r), 0);
    end
    bad_b_pct = 0; bad_r_pct = 0; corrupt_pct = 0;

    // watchdog: write response withheld
    max_delay = 0;
    do_reset("pre_timeout");
    drop_b = 1;
    start_run();
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (bready) begin seen = 1; break; end
    end
    if (!seen) fail_now("timeout_bready", "bready never asserted");
    seen = 0; cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (timeout) begin seen = 1; cyc = n; break; end
    end
    if (!seen) fail_now("timeout_flag", "timeout never asserted");
    chk("timeout_cycles", cyc, TO);
    chk("timeout_bready_drop", bready, 1'b0);
    wait_done(-1, cyc);
    check_result("timeout", 1);
    do_reset("post_timeout");
    drop_b = 0;

    // reset while a read is outstanding, then a fresh run
    max_delay = 3;
    start_run();
    seen = 0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (rready) begin seen = 1; break; end
    end
    if (!seen) fail_now("midrun_rd_resp", "RD_RESP never reached");
    do_reset("midrun");
    start_run();
    wait_done(-1, cyc);
    check_result("after_reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axilite_traffic_gen.md
Name: axilite_traffic_gen

Overview:
- Scripted AXI4-Lite master directly upstream of axilite_noc_bridge; drives the bridge's m_axi_* slave port.
- On start, writes NUM_TXN words at ascending addresses, then reads every word back and compares it against the expected pattern.
- Reports done, pass/fail, a saturating error count and a timeout flag.
- Self-checking traffic source for bridge + memory-controller integration benches.

Parameters:
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 64, AXI data width.
- STROBE_WIDTH, DATA_WIDTH/8, write strobe width.
- NUM_TXN, 16, words written then read (1..256).
- BASE_ADDR, 64'h0, address of word 0.
- ADDR_STRIDE, 8, byte increment between words.
- DATA_SEED, 64'hA5A5_0000_5A5A_0000, pattern for word 0.
- DATA_INCR, 64'h0000_0001_0000_0001, pattern increment per word.
- TIMEOUT, 1024, max cycles per transaction phase before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  one-cycle pulse; launches a run.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  valid when done: err_count==0 and no timeout.
- timeout  out  1  run aborted by watchdog.
- err_count  out  16  saturating count of bad responses and data mismatches.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awready  in  1  write address ready.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_wstrb  out  STROBE_WIDTH  write strobe; all ones.
- m_axi_wdata  out  DATA_WIDTH  write data.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_bresp  in  2  write response code.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_araddr  out  ADDR_WIDTH  read address.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- m_axi_rresp  in  2  read response code.
- m_axi_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all valid/ready outputs 0; busy, done, pass, timeout 0; err_count 0; index 0; FSM in IDLE.
- Addressing: addr(i) = BASE_ADDR + i*ADDR_STRIDE.
- Data: data(i) = DATA_SEED + i*DATA_INCR, both modulo 2^width.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN.
- IDLE:
  - start -> WR_REQ, index=0, busy=1, done=0, err_count=0, timeout=0.
  - start while busy is ignored.
- WR_REQ:
  - awvalid and wvalid assert together, first cycle after entry.
  - Each valid is held, with address/data stable, until its own handshake; the two handshakes may land in any order or the same cycle.
  - Once both complete -> WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: if bresp != 2'b00, err_count++.
  - If index==NUM_TXN-1 -> RD_REQ with index=0; else index++ -> WR_REQ.
  - The next request's valids assert no earlier than the cycle after the B handshake.
- RD_REQ: arvalid held with stable araddr until arready -> RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: err_count++ if rresp != 2'b00 or rdata != data(index); a bad rresp combined with a mismatch counts once.
  - Last index -> FIN; else index++ -> RD_REQ.
- FIN: busy=0, done=1, pass=(err_count==0 && !timeout) -> IDLE next cycle; done and pass hold until the next start.
- err_count saturates at 16'hFFFF.
- Watchdog:
  - Cycle counter resets on every state entry.
  - If it reaches TIMEOUT in WR_REQ/WR_RESP/RD_REQ/RD_RESP: timeout=1, all valids/readies drop next cycle -> FIN. An outstanding AXI transaction is abandoned; the bench must reset before reuse.
- Reset mid-run: next cycle all outputs are at their reset values; no partial handshakes are held.
- Latency with a zero-wait responder: 2 cycles per write (request, response) and 2 per read, plus 1 for FIN.

Decomposition:
- Shared package axilite_tg_pkg:
  - FSM state enum.
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - ERR_CNT_WIDTH=16.
- Sub-module axilite_tg_watchdog: clear/enable inputs, TIMEOUT parameter, expired output. Instantiated once.

Test Plan:
- Nominal: NUM_TXN=4, bridge + fake_mem_ctrl, start pulse -> 4 writes to 0x0/0x8/0x10/0x18 carrying DATA_SEED+i*DATA_INCR, 4 matching reads; done=1, pass=1, err_count=0, timeout=0.
- Channel skew: awready delayed 5 cycles, wready immediate -> wvalid drops after the W handshake, awvalid and awaddr stay stable until cycle 5, no duplicate write, pass=1.
- Bad response: responder returns bresp=2'b10 on write 1 and rresp=2'b10 with correct data on read 2 -> err_count=2, pass=0.
- Data corruption: rdata bit 0 flipped on read 3 -> err_count=1, pass=0, all 4 reads still completed.
- Timeout: bvalid never asserted, TIMEOUT=16 -> 16 cycles after WR_RESP entry timeout=1, bready=0, done=1, pass=0.
- Reset mid-run: rst pulsed during RD_RESP, then start ignored while busy was high before reset -> outputs at reset values the cycle after rst; a fresh start completes with pass=1.
